// File: rtl/chien_search_ctrl.sv
// Chien search sequencer for RS(15,11) over GF(16), t=2: loads the cells, then evaluates Lambda(alpha^i) for i=1..15.
// Latency: START accepted -> DONE 17 cycles; START is ignored while BUSY or in FINISH (no queueing).
module chien_search_ctrl #(
    parameter int N       = 15,
    parameter int MAX_ERR = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [1:0]   LAMBDA_DEG,
    input  logic [3:0]   CHIEN_0,
    input  logic [3:0]   CHIEN_1,
    input  logic [3:0]   CHIEN_2,
    output logic         CONTROL,
    output logic         BUSY,
    output logic         ERR_VALID,
    output logic [3:0]   ERR_POS,
    output logic [N-1:0] ERR_MASK,
    output logic [1:0]   ERR_COUNT,
    output logic         DONE,
    output logic         FAIL
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [1:0] MAX_ERR_W = 2'(MAX_ERR);
    localparam logic [3:0] LAST_I    = 4'(N);

    state_t         state_q, state_d;
    logic [3:0]     i_q, i_d;
    logic [1:0]     deg_q, deg_d;
    logic           err_valid_q, err_valid_d;
    logic [3:0]     err_pos_q, err_pos_d;
    logic [N-1:0]   err_mask_q, err_mask_d;
    logic [1:0]     err_count_q, err_count_d;
    logic           done_q, done_d;
    logic           fail_q, fail_d;
    logic [3:0]     syn;

    assign syn = CHIEN_0 ^ CHIEN_1 ^ CHIEN_2;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        deg_d       = deg_q;
        err_valid_d = 1'b0;
        err_pos_d   = err_pos_q;
        err_mask_d  = err_mask_q;
        err_count_d = err_count_q;
        done_d      = 1'b0;
        fail_d      = fail_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d     = ST_LOAD;
                    deg_d       = LAMBDA_DEG;
                    err_mask_d  = '0;
                    err_count_d = 2'd0;
                    fail_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEARCH;
                i_d     = 4'd1;
            end
            ST_SEARCH: begin
                if (syn == 4'd0) begin
                    err_valid_d = 1'b1;
                    // 15 - i wraps i=15 onto position 0 naturally.
                    err_pos_d   = 4'd15 - i_q;
                    err_mask_d[err_pos_d] = 1'b1;
                    if (err_count_q != 2'd3)
                        err_count_d = err_count_q + 2'd1;
                end
                i_d = i_q + 4'd1;
                if (i_q == LAST_I) begin
                    state_d = ST_FINISH;
                    i_d     = 4'd0;
                    done_d  = 1'b1;
                    // Uses the count including a possible root at i=15.
                    fail_d  = (err_count_d != deg_q) || (deg_q > MAX_ERR_W);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            i_q         <= 4'd0;
            deg_q       <= 2'd0;
            err_valid_q <= 1'b0;
            err_pos_q   <= 4'd0;
            err_mask_q  <= '0;
            err_count_q <= 2'd0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            deg_q       <= deg_d;
            err_valid_q <= err_valid_d;
            err_pos_q   <= err_pos_d;
            err_mask_q  <= err_mask_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign CONTROL   = (state_q == ST_LOAD);
    assign BUSY      = (state_q == ST_LOAD) || (state_q == ST_SEARCH);
    assign ERR_VALID = err_valid_q;
    assign ERR_POS   = err_pos_q;
    assign ERR_MASK  = err_mask_q;
    assign ERR_COUNT = err_count_q;
    assign DONE      = done_q;
    assign FAIL      = fail_q;

endmodule

// File: tb/tb_chien_search_ctrl.sv
// Bench for chien_search_ctrl: models the three Chien cells and scoreboards expected roots from a direct Lambda(alpha^i) evaluation.
module tb_chien_search_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  LAMBDA_DEG = 2'd0;
    logic [3:0]  CHIEN_0, CHIEN_1, CHIEN_2;
    logic        CONTROL, BUSY, ERR_VALID, DONE, FAIL;
    logic [3:0]  ERR_POS;
    logic [14:0] ERR_MASK;
    logic [1:0]  ERR_COUNT;

    int checks = 0;
    int errors = 0;

    logic [3:0] gam0 = 4'd0, gam1 = 4'd0, gam2 = 4'd0;

    typedef struct {
        int         cyc;
        logic [3:0] pos;
    } ev_t;
    ev_t exp_q[$];

    chien_search_ctrl #(.N(15), .MAX_ERR(2)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .LAMBDA_DEG(LAMBDA_DEG),
        .CHIEN_0(CHIEN_0), .CHIEN_1(CHIEN_1), .CHIEN_2(CHIEN_2),
        .CONTROL(CONTROL), .BUSY(BUSY), .ERR_VALID(ERR_VALID), .ERR_POS(ERR_POS),
        .ERR_MASK(ERR_MASK), .ERR_COUNT(ERR_COUNT), .DONE(DONE), .FAIL(FAIL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'd0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r = r ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    // Chien cell j: loads Gamma_j*alpha^j on CONTROL, else multiplies by alpha^j.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CHIEN_0 <= 4'd0;
            CHIEN_1 <= 4'd0;
            CHIEN_2 <= 4'd0;
        end else if (CONTROL) begin
            CHIEN_0 <= gam0;
            CHIEN_1 <= gf_mul(gam1, 4'd2);
            CHIEN_2 <= gf_mul(gam2, 4'd4);
        end else begin
            CHIEN_1 <= gf_mul(CHIEN_1, 4'd2);
            CHIEN_2 <= gf_mul(CHIEN_2, 4'd4);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the scoreboard, runs one search and checks roots, timing and final results.
    task automatic run_search(input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] g2,
                              input logic [1:0] deg, input bit poke_busy);
        logic [3:0]  x, s;
        logic [14:0] exp_mask;
        int          exp_cnt;
        logic        exp_fail;
        bit          done_seen;
        ev_t         e;
        gam0 = g0; gam1 = g1; gam2 = g2;
        exp_q.delete();
        exp_mask = 15'd0;
        exp_cnt  = 0;
        x = 4'd1;
        for (int i = 1; i <= 15; i++) begin
            x = gf_mul(x, 4'd2);
            s = g0 ^ gf_mul(g1, x) ^ gf_mul(g2, gf_mul(x, x));
            if (s == 4'd0) begin
                e.cyc = i + 1;
                e.pos = 4'((15 - i) % 15);
                exp_q.push_back(e);
                exp_mask[e.pos] = 1'b1;
                if (exp_cnt < 3) exp_cnt++;
            end
        end
        exp_fail = (exp_cnt != int'(deg)) || (deg > 2'd2);

        START = 1'b1;
        LAMBDA_DEG = deg;
        @(posedge CLK); #1;
        START = 1'b0;
        LAMBDA_DEG = ~deg;
        check("load_control", CONTROL, 1);
        check("load_busy", BUSY, 1);
        check("start_clears_count", ERR_COUNT, 0);
        check("start_clears_fail", FAIL, 0);

        done_seen = 0;
        for (int k = 1; k <= 20 && !done_seen; k++) begin
            @(posedge CLK); #1;
            if (poke_busy) START = (k == 5);
            if (k < 16) check("search_control", CONTROL, 0);
            if (ERR_VALID) begin
                if (exp_q.size() == 0) begin
                    check("spurious_err_valid_cycle", k, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_pos", ERR_POS, e.pos);
                    check("err_cycle", k, e.cyc);
                end
            end
            if (DONE) begin
                done_seen = 1;
                check("done_cycle", k, 16);
                check("done_mask", ERR_MASK, exp_mask);
                check("done_count", ERR_COUNT, exp_cnt);
                check("done_fail", FAIL, exp_fail);
                check("done_busy", BUSY, 0);
            end
        end
        check("done_seen", done_seen, 1);
        check("missing_roots", exp_q.size(), 0);

        if (poke_busy) START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("idle_busy", BUSY, 0);
        check("idle_done", DONE, 0);
        check("idle_err_valid", ERR_VALID, 0);
        check("hold_mask", ERR_MASK, exp_mask);
        check("hold_count", ERR_COUNT, exp_cnt);
        check("hold_fail", FAIL, exp_fail);
    endtask

    initial begin
        #12;
        check("rst_control", CONTROL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_valid", ERR_VALID, 0);
        check("rst_pos", ERR_POS, 0);
        check("rst_mask", ERR_MASK, 0);
        check("rst_count", ERR_COUNT, 0);
        check("rst_done", DONE, 0);
        check("rst_fail", FAIL, 0);
        RESET = 1'b0;
        @(negedge CLK);

        run_search(4'd1, 4'd8, 4'd0, 2'd1, 0);   // single root, position 3
        run_search(4'd1, 4'd7, 4'd6, 2'd2, 1);   // positions 5 and 0, START pokes ignored
        run_search(4'd1, 4'd8, 4'd0, 2'd2, 0);   // degree mismatch -> FAIL
        run_search(4'd0, 4'd0, 4'd0, 2'd0, 0);   // all-zero locator
        run_search(4'd1, 4'd0, 4'd0, 2'd0, 0);   // Lambda = 1
        run_search(4'd3, 4'd5, 4'd9, 2'd3, 0);   // degree beyond t

        // Asynchronous reset in the middle of a search.
        gam0 = 4'd0; gam1 = 4'd0; gam2 = 4'd0;
        START = 1'b1;
        LAMBDA_DEG = 2'd0;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (7) @(posedge CLK);
        #2;
        check("pre_rst_count", ERR_COUNT, 3);
        check("pre_rst_busy", BUSY, 1);
        RESET = 1'b1;
        #1;
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_control", CONTROL, 0);
        check("mid_rst_valid", ERR_VALID, 0);
        check("mid_rst_pos", ERR_POS, 0);
        check("mid_rst_mask", ERR_MASK, 0);
        check("mid_rst_count", ERR_COUNT, 0);
        check("mid_rst_done", DONE, 0);
        check("mid_rst_fail", FAIL, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        run_search(4'd1, 4'd7, 4'd6, 2'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chien_search_ctrl.md
Name: chien_search_ctrl

Overview:
- Sequencer for the RS(15,11) Chien search stage over GF(16), primitive polynomial x^4+x+1, t=2.
- Drives the shared CONTROL line of the three Chien cells (cell j multiplies by alpha^j):
  - one load cycle loads the error-locator coefficients;
  - then 15 evaluation cycles follow.
- Each cycle it XORs the three cell outputs to form Lambda(alpha^i) and detects roots.
- Reports error positions, an error bitmap, an error count and a decoder-failure flag to the Forney/correction stage.

Parameters:
- N, 15, codeword length; evaluation cycles per search. Only 15 is supported.
- MAX_ERR, 2, correction capability t.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset. Same net as the Chien cells' RESET.
- START  input  1  request a search. Sampled only in IDLE.
- LAMBDA_DEG  input  2  degree of the error locator from Berlekamp-Massey. Latched when START is accepted.
- CHIEN_0  input  4  output register of Chien cell 0.
- CHIEN_1  input  4  output register of Chien cell 1.
- CHIEN_2  input  4  output register of Chien cell 2.
- CONTROL  output  1  cell load select; 1 only in the LOAD state.
- BUSY  output  1  high in LOAD and SEARCH.
- ERR_VALID  output  1  registered one-cycle pulse per root found.
- ERR_POS  output  4  codeword position of the current root. Valid while ERR_VALID is high.
- ERR_MASK  output  15  bitmap of error positions; bit p is set for position p.
- ERR_COUNT  output  2  roots found; saturates at 3.
- DONE  output  1  one-cycle pulse; the results are final.
- FAIL  output  1  uncorrectable flag. Valid while DONE is high; held until the next START.

Behaviour:
- FSM states: IDLE, LOAD, SEARCH, FINISH. The FSM is registered; CONTROL decodes combinationally from the state.
- Reset: state=IDLE, eval counter i=0, latched degree=0, all outputs 0. Takes effect immediately, including mid-search; no partial results survive.
- IDLE:
  - START=1 at edge E0 → LOAD.
  - Clear ERR_MASK, ERR_COUNT, FAIL and latch LAMBDA_DEG at that edge.
- LOAD: CONTROL=1 for exactly one cycle.
  - At E1 the cells load Gamma_j*alpha^j.
  - → SEARCH, i=1.
- SEARCH:
  - During cycle i (between E_i and E_{i+1}), S = CHIEN_0 ^ CHIEN_1 ^ CHIEN_2 = Lambda(alpha^i).
  - At E_{i+1}, if S==0:
    - ERR_VALID<=1;
    - ERR_POS<=(15-i) mod 15 (i=15 gives position 0);
    - ERR_MASK[ERR_POS]<=1;
    - ERR_COUNT<=sat(ERR_COUNT+1).
  - Otherwise ERR_VALID<=0.
  - i increments. At E16 (i=15 evaluated) → FINISH.
- FINISH:
  - DONE=1 for one cycle. ERR_VALID for the i=15 root is high in this same cycle.
  - FAIL=1 if ERR_COUNT != latched degree, or latched degree > MAX_ERR.
  - → IDLE at the next edge.
- Latency: START accepted at E0 → DONE high in the cycle after E16, i.e. 17 cycles.
- Back-to-back operation: a new START is accepted on the cycle after FINISH. START in LOAD, SEARCH or FINISH is ignored and not queued.
- ERR_COUNT saturates at 3. A saturated count always gives FAIL.
- Degree 0 (Lambda=1): S is never 0 → count 0, FAIL=0.
- All-zero locator: S=0 on every cycle → 15 ERR_VALID pulses, mask 0x7FFF, count 3, FAIL=1.
- Outputs ERR_POS, ERR_MASK, ERR_COUNT and FAIL hold their values in IDLE until the next accepted START.

Test Plan:
1. Reset → all outputs 0, CONTROL=0. START with Gamma={1,8,0}, deg=1 (Lambda=1+alpha^3x) → single ERR_VALID after E13 with ERR_POS=3; DONE at cycle 17; ERR_MASK=0x0008, COUNT=1, FAIL=0.
2. Gamma={1,7,6}, deg=2 (roots for positions 5 and 0) → ERR_POS=5 after E11, then ERR_POS=0 coincident with DONE; MASK=0x0021, COUNT=2, FAIL=0.
3. Gamma={1,8,0} with deg=2 → one root at position 3, COUNT=1, FAIL=1.
4. Gamma={0,0,0}, deg=0 → 15 pulses, MASK=0x7FFF, COUNT=3, FAIL=1.
5. Gamma={1,0,0}, deg=0 → no ERR_VALID, COUNT=0, FAIL=0.
6. RESET asserted at SEARCH i=7 (asynchronous, mid-cycle) → immediately IDLE with outputs 0. START pulses during BUSY are ignored; a START the cycle after DONE is accepted.
